// File: rtl/noc_router_pkg.sv
// Port encoding and dimension-ordered XY route computation shared by the
// credit-based mesh router and its testbench-visible port indices.
package noc_router_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        P_N = 3'd0,
        P_S = 3'd1,
        P_E = 3'd2,
        P_W = 3'd3,
        P_L = 3'd4
    } port_e;

    // Coordinates arrive zero-extended to 16 bits so one function serves any COORD_W.
    function automatic port_e xy_route(input logic [15:0] dst_x, input logic [15:0] dst_y,
                                       input logic [15:0] x_id, input logic [15:0] y_id);
        port_e p;
        if (dst_x > x_id)      p = P_E;
        else if (dst_x < x_id) p = P_W;
        else if (dst_y > y_id) p = P_N;
        else if (dst_y < y_id) p = P_S;
        else                   p = P_L;
        return p;
    endfunction

endpackage

// File: rtl/router_in_fifo.sv
// Per-input flit FIFO: a slot freed by a pop is reusable by a push on the
// same edge; a push that finds no room is dropped and flagged as overflow.
module router_in_fifo #(
    parameter int FLIT_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] wr_data,
    output logic [FLIT_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/noc_router_credit.sv
// 5-port XY mesh router for single-flit packets: input FIFOs, per-output
// round-robin arbitration and credit-based flow control.
module noc_router_credit
    import noc_router_pkg::*;
#(
    parameter int FLIT_W  = 16,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 3,
    parameter int X_ID    = 0,
    parameter int Y_ID    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_W-1:0]    data_i  [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] valid_i,
    input  logic [NUM_PORTS-1:0] incr_i,
    output logic [FLIT_W-1:0]    data_o  [NUM_PORTS],
    output logic [NUM_PORTS-1:0] valid_o,
    output logic [NUM_PORTS-1:0] incr_o,
    output logic [NUM_PORTS-1:0] err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
    localparam logic [15:0]   X_POS = 16'(X_ID);
    localparam logic [15:0]   Y_POS = 16'(Y_ID);

    logic [FLIT_W-1:0]    head [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full_unused;
    logic [NUM_PORTS-1:0] overflow;
    logic [NUM_PORTS-1:0] pop;
    port_e                route [NUM_PORTS];
    logic [NUM_PORTS-1:0] req [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant;
    logic [2:0]           winner [NUM_PORTS];
    logic [2:0]           ptr [NUM_PORTS];
    logic [CW-1:0]        credit [NUM_PORTS];

    genvar g;
    generate
        for (g = 0; g < NUM_PORTS; g++) begin : g_in
            router_in_fifo #(
                .FLIT_W(FLIT_W),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push    (valid_i[g]),
                .pop     (pop[g]),
                .wr_data (data_i[g]),
                .head    (head[g]),
                .full    (full_unused[g]),
                .empty   (empty[g]),
                .overflow(overflow[g])
            );

            assign route[g] = xy_route(16'(head[g][FLIT_W-1 -: COORD_W]),
                                       16'(head[g][FLIT_W-COORD_W-1 -: COORD_W]),
                                       X_POS, Y_POS);
        end
    endgenerate

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            req[o] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                req[o][p] = !empty[p] && (int'(route[p]) == o);
            end
        end
    end

    always_comb begin
        logic [2:0] idx;
        idx   = '0;
        grant = '0;
        pop   = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            winner[o] = '0;
            // Scanning downward lets the requester nearest at/after ptr overwrite farther ones.
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                idx = 3'((int'(ptr[o]) + k) % NUM_PORTS);
                if (req[o][idx] && credit[o] != '0) begin
                    grant[o]  = 1'b1;
                    winner[o] = idx;
                end
            end
            if (grant[o]) pop[winner[o]] = 1'b1;
        end
    end

    // Output stage: granted flits, credit returns, pointers and credit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= '0;
            incr_o  <= '0;
            err_o   <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                data_o[o] <= '0;
                ptr[o]    <= '0;
                credit[o] <= CREDIT_MAX;
            end
        end else begin
            valid_o <= grant;
            incr_o  <= pop;
            err_o   <= err_o | overflow;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (grant[o]) begin
                    data_o[o] <= head[winner[o]];
                    ptr[o]    <= (winner[o] == 3'(NUM_PORTS - 1)) ? 3'd0 : winner[o] + 3'd1;
                end
                if (grant[o] && !incr_i[o]) begin
                    credit[o] <= credit[o] - 1'b1;
                end else if (incr_i[o] && !grant[o] && credit[o] != CREDIT_MAX) begin
                    credit[o] <= credit[o] + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/noc_router_credit.md
Name: noc_router_credit

Overview:
- Parametrised 5-port mesh router: North, South, East, West, Local.
- Single-flit packets, generic flit width, per-input FIFO buffering, dimension-ordered XY routing.
- Per-output round-robin arbitration and credit-based flow control using one-cycle incr pulses.
- One instance per mesh tile; neighbours connect data/valid/incr port-to-port.

Parameters:
FLIT_W, 16, flit width in bits
DEPTH, 4, input FIFO depth in flits (power of 2, >=2); also initial credit count per output
COORD_W, 3, width of each destination coordinate field
X_ID, 0, this router's X coordinate
Y_ID, 0, this router's Y coordinate

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
data_i  in  [5][FLIT_W]  flit in per port; index 0=N 1=S 2=E 3=W 4=L
valid_i  in  [5]  data_i[p] valid this cycle
incr_i  in  [5]  credit return from the downstream receiver of output p (one flit freed)
data_o  out  [5][FLIT_W]  flit out per port
valid_o  out  [5]  data_o[p] valid, one-cycle pulse per flit
incr_o  out  [5]  credit return to the upstream sender on input p
err_o  out  [5]  sticky overflow flag per input

Behaviour:
- Reset (async, rst=1): all FIFOs empty; data_o, valid_o, incr_o, err_o = 0; credit counters = DEPTH; RR pointers = 0.
- Flit fields: dst_x = flit[FLIT_W-1 -: COORD_W]; dst_y = the next COORD_W bits below it. Remaining bits are payload, forwarded unchanged.
- Route on FIFO head:
  - dst_x > X_ID -> E; dst_x < X_ID -> W.
  - Otherwise dst_y > Y_ID -> N; dst_y < Y_ID -> S.
  - Otherwise -> L. Local-to-local loopback is legal.
- Write: valid_i[p] with FIFO p not full -> push at the clock edge.
- Overflow: valid_i[p] with FIFO p full is an upstream protocol violation. Drop the flit, set err_o[p]; it stays set until reset.
- Request: non-empty input p requests output route(head_p). Each input heads at most one flit, so there are no input-side conflicts.
- Grant to output o requires requests present and credit[o] > 0.
  - RR winner = first requester at or after ptr[o], scanning upward modulo 5.
  - After a grant, ptr[o] = winner+1 mod 5. No grant -> ptr unchanged.
- On grant, at the same edge:
  - Pop the winner's FIFO.
  - data_o[o] <= head, valid_o[o] <= 1, incr_o[winner] <= 1.
  - All non-granted valid_o/incr_o bits are 0 the next cycle; data_o holds its last value.
- Latency: flit sampled at edge k appears on data_o/valid_o in the cycle after edge k+1 (2 cycles) when uncontended with credit available. Matching incr_o is in the same cycle as valid_o.
- Credit counter per output, width clog2(DEPTH+1):
  - grant only -> -1; incr_i only -> +1; both in one cycle -> unchanged.
  - incr_i at credit == DEPTH saturates at DEPTH (protocol error, no flag).
- Credit = 0: output stalls, flits wait in their FIFOs, no loss. The RR pointer does not advance.
- Push and pop on the same FIFO in the same cycle are legal, including when full: the pop frees a slot for the push that cycle. Count is unchanged.
- Reset asserted mid-transfer discards all buffered flits and in-flight outputs immediately (async). Credits return to DEPTH.

Decomposition:
- Package noc_router_pkg holds:
  - localparam NUM_PORTS = 5.
  - enum port_e {P_N, P_S, P_E, P_W, P_L}.
  - function xy_route(dst_x, dst_y, x_id, y_id) returning port_e.
- Sub-module router_in_fifo: parametrised FLIT_W/DEPTH sync FIFO with push/pop/full/empty/head and overflow detect. Instantiate 5 times.
- Arbitration and credit counters stay inline in noc_router_credit.

Test Plan:
- Basic route: X_ID=1, Y_ID=1, DEPTH=4; local flit dst(3,1) payload 0x0AB at cycle 0 -> valid_o[E]=1 with identical data at cycle 2; incr_o[L]=1 at cycle 2; all other outputs 0.
- Contention: N and S both send dst=self at cycle 0, ptr[L]=0 -> N flit on data_o[L] at cycle 2, S flit at cycle 3; incr_o[N] at cycle 2, incr_o[S] at cycle 3; ptr[L] ends at 2.
- Credit exhaustion: 6 flits from W to E destination on consecutive cycles, incr_i[E] held 0 -> exactly 4 valid_o[E] pulses, then stall. One incr_i[E] pulse -> 5th flit emitted 1 cycle later.
- Simultaneous credit: credit[E]=1, a grant to E in the same cycle as an incr_i[E] pulse -> credit stays 1; the next flit is granted on the following cycle.
- Overflow: output N credit=0, drive 5 flits into input S toward N -> err_o[S]=1 after the 5th; after 4 credits are returned, only the first 4 flits emerge, in order.
- Reset mid-operation: assert rst with 3 flits buffered and valid_o high -> valid_o, incr_o, err_o drop to 0 without a clock edge. After release, no stale flits are emitted and a fresh flit takes 2 cycles.
